// File: rtl/uop_sequencer_pkg.sv
// rtl/uop_sequencer_pkg.sv - shared FSM encoding and micro-op ROM contents for uop_sequencer
//
// Purpose: holds the sequencer state encoding and the ROM programming used by uop_rom.
// ROM entry layout (width UOPW+1): {last, uop[UOPW-1:0]}; bit UOPW is the last flag.
// Ports: none (package).
package uop_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEQ  = 2'd1,
    ST_INT  = 2'd2
  } state_e;

  // Length marker for a sequence that never sets its last bit; the step
  // limit in the sequencer is what terminates it.
  localparam int ROM_LEN_RUNAWAY = 32'h7FFF_FFFF;

  // Programmed length per sequence id; 0 means the sequence is unprogrammed.
  function automatic int rom_seq_len(input int seq);
    case (seq)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return 5;
      4:       return ROM_LEN_RUNAWAY;
      5:       return 4;
      7:       return 3;   // interrupt entry sequence
      default: return 0;
    endcase
  endfunction

  // Programmed micro-op: tagged with sequence id and step so every entry is distinct.
  function automatic logic [31:0] rom_uop_pattern(input int seq, input int step);
    return {16'hC0DE, seq[7:0], step[7:0]};
  endfunction

endpackage

// File: rtl/uop_rom.sv
// rtl/uop_rom.sv - combinational micro-op ROM lookup
//
// Purpose: maps (sequence id, step) to a ROM entry {last, uop}.
// Unprogrammed entries (unknown sequence or step beyond its length) read uop=0, last=1.
// Ports:
//   i_seq   in  SEQW    sequence id
//   i_step  in  STPW    step within the sequence
//   o_entry out UOPW+1  {last, uop}
module uop_rom
  import uop_sequencer_pkg::*;
#(
  parameter int UOPW = 64,
  parameter int SEQW = 3,
  parameter int STPW = 3
) (
  input  logic [SEQW-1:0] i_seq,
  input  logic [STPW-1:0] i_step,
  output logic [UOPW:0]   o_entry
);

  int w_len;

  always_comb begin
    w_len   = rom_seq_len(int'(i_seq));
    o_entry = {1'b1, {UOPW{1'b0}}};
    if (int'(i_step) < w_len) begin
      o_entry[UOPW-1:0] = UOPW'(rom_uop_pattern(int'(i_seq), int'(i_step)));
      o_entry[UOPW]     = (int'(i_step) == w_len - 1);
    end
  end

endmodule

// File: rtl/uop_sequencer.sv
// rtl/uop_sequencer.sv - micro-op sequencer: pass-through, ROM sequences and interrupt entry
//
// Purpose: accepts decoded instructions and emits one micro-op per cycle, either the
// directly decoded uop or a ROM sequence; an interrupt runs sequence INT_SEQ.
// Ports:
//   clk, reset (async active-low), flush (sync squash)
//   handle_int / handle_int_done        interrupt request level / completion pulse
//   in_valid/in_ready, in_uop, in_seq_valid, in_seq_id, in_imm, in_pc   instruction in
//   out_valid/out_ready, out_uop, out_imm, out_pc, out_last              micro-op out
//   busy                                 high while a ROM sequence (SEQ or INT) runs
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter  int UOPW    = 64,
  parameter  int SEQS    = 8,
  parameter  int MAXLEN  = 8,
  parameter  int IADDRW  = 32,
  parameter  int INT_SEQ = SEQS - 1,
  localparam int SEQW    = (SEQS > 1) ? $clog2(SEQS) : 1,
  localparam int STPW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              handle_int,
  output logic              handle_int_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [UOPW-1:0]   in_uop,
  input  logic              in_seq_valid,
  input  logic [SEQW-1:0]   in_seq_id,
  input  logic [47:0]       in_imm,
  input  logic [IADDRW-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [UOPW-1:0]   out_uop,
  output logic [47:0]       out_imm,
  output logic [IADDRW-1:0] out_pc,
  output logic              out_last,
  output logic              busy
);

  state_e             r_state, w_state_nx;
  logic [SEQW-1:0]    r_seq, w_seq_nx;
  logic [STPW-1:0]    r_step, w_step_nx;
  logic [47:0]        r_imm, w_imm_nx;
  logic [IADDRW-1:0]  r_pc, w_pc_nx;
  logic               r_out_valid, w_out_valid_nx;
  logic [UOPW-1:0]    r_out_uop, w_out_uop_nx;
  logic [47:0]        r_out_imm, w_out_imm_nx;
  logic [IADDRW-1:0]  r_out_pc, w_out_pc_nx;
  logic               r_out_last, w_out_last_nx;
  logic               r_out_int, w_out_int_nx;  // held output belongs to the interrupt sequence
  logic [UOPW:0]      w_rom_entry;
  logic               w_ld;
  logic               w_last;

  uop_rom #(.UOPW(UOPW), .SEQW(SEQW), .STPW(STPW)) u_rom (
    .i_seq   (r_seq),
    .i_step  (r_step),
    .o_entry (w_rom_entry)
  );

  always_comb begin
    w_ld           = !r_out_valid || out_ready;
    // Forced termination keeps the step counter from ever wrapping.
    w_last         = w_rom_entry[UOPW] || (r_step == STPW'(MAXLEN - 1));
    w_state_nx     = r_state;
    w_seq_nx       = r_seq;
    w_step_nx      = r_step;
    w_imm_nx       = r_imm;
    w_pc_nx        = r_pc;
    w_out_valid_nx = r_out_valid;
    w_out_uop_nx   = r_out_uop;
    w_out_imm_nx   = r_out_imm;
    w_out_pc_nx    = r_out_pc;
    w_out_last_nx  = r_out_last;
    w_out_int_nx   = r_out_int;
    in_ready       = 1'b0;

    if (flush) begin
      w_state_nx     = ST_IDLE;
      w_step_nx      = '0;
      w_out_valid_nx = 1'b0;
      w_out_int_nx   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ld) w_out_valid_nx = 1'b0;  // previous output drained, nothing new yet
          if (handle_int) begin
            w_state_nx = ST_INT;
            w_seq_nx   = SEQW'(INT_SEQ);
            w_step_nx  = '0;
            w_imm_nx   = '0;
            w_pc_nx    = in_pc;
          end else begin
            in_ready = w_ld;
            if (in_valid && w_ld) begin
              if (in_seq_valid) begin
                w_state_nx = ST_SEQ;
                w_seq_nx   = in_seq_id;
                w_step_nx  = '0;
                w_imm_nx   = in_imm;
                w_pc_nx    = in_pc;
              end else begin
                w_out_valid_nx = 1'b1;
                w_out_uop_nx   = in_uop;
                w_out_imm_nx   = in_imm;
                w_out_pc_nx    = in_pc;
                w_out_last_nx  = 1'b1;
                w_out_int_nx   = 1'b0;
              end
            end
          end
        end
        ST_SEQ, ST_INT: begin
          if (w_ld) begin
            w_out_valid_nx = 1'b1;
            w_out_uop_nx   = w_rom_entry[UOPW-1:0];
            w_out_imm_nx   = r_imm;
            w_out_pc_nx    = r_pc;
            w_out_last_nx  = w_last;
            w_out_int_nx   = (r_state == ST_INT);
            if (w_last) begin
              w_state_nx = ST_IDLE;
              w_step_nx  = '0;
            end else begin
              w_step_nx  = r_step + 1'b1;
            end
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_seq       <= '0;
      r_step      <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_out_valid <= 1'b0;
      r_out_uop   <= '0;
      r_out_imm   <= '0;
      r_out_pc    <= '0;
      r_out_last  <= 1'b0;
      r_out_int   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_seq       <= w_seq_nx;
      r_step      <= w_step_nx;
      r_imm       <= w_imm_nx;
      r_pc        <= w_pc_nx;
      r_out_valid <= w_out_valid_nx;
      r_out_uop   <= w_out_uop_nx;
      r_out_imm   <= w_out_imm_nx;
      r_out_pc    <= w_out_pc_nx;
      r_out_last  <= w_out_last_nx;
      r_out_int   <= w_out_int_nx;
    end
  end

  assign out_valid       = r_out_valid;
  assign out_uop         = r_out_uop;
  assign out_imm         = r_out_imm;
  assign out_pc          = r_out_pc;
  assign out_last        = r_out_last;
  assign busy            = (r_state != ST_IDLE);
  // Completion is the downstream handshake on the final interrupt micro-op itself.
  assign handle_int_done = r_out_valid && out_ready && r_out_last && r_out_int && !flush;

endmodule

// File: tb/tb_uop_sequencer.sv
// tb/tb_uop_sequencer.sv - scoreboard testbench for uop_sequencer
module tb_uop_sequencer;

  logic        clk, reset, flush, handle_int, handle_int_done;
  logic        in_valid, in_ready, in_seq_valid;
  logic [63:0] in_uop;
  logic [2:0]  in_seq_id;
  logic [47:0] in_imm;
  logic [31:0] in_pc;
  logic        out_valid, out_ready, out_last, busy;
  logic [63:0] out_uop;
  logic [47:0] out_imm;
  logic [31:0] out_pc;

  uop_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush), .handle_int(handle_int),
    .handle_int_done(handle_int_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_uop(in_uop), .in_seq_valid(in_seq_valid), .in_seq_id(in_seq_id),
    .in_imm(in_imm), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_uop(out_uop), .out_imm(out_imm), .out_pc(out_pc), .out_last(out_last),
    .busy(busy)
  );

  typedef struct {
    logic [63:0] uop;
    logic [47:0] imm;
    logic [31:0] pc;
    logic        last;
    logic        is_int;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    rdy_mode = 1;  // 0 random, 1 always ready, 2 stalled
  // Reference sequence lengths: -1 never terminates by itself, 0 unprogrammed.
  int    model_len[8] = '{1, 2, 3, 5, -1, 4, 0, 3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_seq(input int s, input logic [47:0] imm, input logic [31:0] pc,
                          input logic is_int);
    beat_t b;
    int    cnt;
    b.imm = imm; b.pc = pc; b.is_int = is_int;
    if (model_len[s] == 0) begin
      b.uop = '0; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      cnt = (model_len[s] < 0 || model_len[s] > 8) ? 8 : model_len[s];
      for (int k = 0; k < cnt; k++) begin
        b.uop  = {32'h0, 16'hC0DE, s[7:0], k[7:0]};
        b.last = (k == cnt - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Monitor: pops and compares on every downstream handshake.
  logic        have_stall = 1'b0, flush_prev = 1'b0;
  logic [63:0] sv_uop;
  logic [47:0] sv_imm;
  logic [31:0] sv_pc;
  logic        sv_last;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      have_stall = 1'b0;
      flush_prev = 1'b0;
    end else begin
      if (flush_prev) begin
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
      end
      if (flush) chk("flush_in_ready", in_ready, 0);
      if (busy) chk("busy_in_ready", in_ready, 0);
      if (have_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_uop", out_uop, sv_uop);
        chk("stall_imm", out_imm, sv_imm);
        chk("stall_pc", out_pc, sv_pc);
        chk("stall_last", out_last, sv_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_uop", out_uop, 64'hDEAD);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_uop", out_uop, e.uop);
          chk("out_imm", out_imm, e.imm);
          chk("out_pc", out_pc, e.pc);
          chk("out_last", out_last, e.last);
          chk("int_done", handle_int_done, e.is_int && e.last && !flush);
        end
      end else begin
        chk("int_done_idle", handle_int_done, 0);
      end
      have_stall = out_valid && !out_ready && !flush;
      sv_uop = out_uop; sv_imm = out_imm; sv_pc = out_pc; sv_last = out_last;
      if (flush) exp_q.delete();
      flush_prev = flush;
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send(input bit sv, input int sid, input logic [63:0] uop,
                      input logic [47:0] imm, input logic [31:0] pc);
    bit    acc = 0;
    beat_t b;
    in_valid = 1'b1; in_seq_valid = sv; in_seq_id = sid[2:0];
    in_uop = uop; in_imm = imm; in_pc = pc;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        if (sv) push_seq(sid, imm, pc, 1'b0);
        else begin
          b.uop = uop; b.imm = imm; b.pc = pc; b.last = 1'b1; b.is_int = 1'b0;
          exp_q.push_back(b);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic do_int(input bit with_flush);
    bit          taken = 0;
    logic [31:0] pc;
    pc = $urandom;
    handle_int = 1'b1; in_valid = 1'b1; in_seq_valid = 1'b0;
    in_uop = {$urandom, $urandom}; in_pc = pc; in_imm = 48'h5555;
    flush = with_flush;
    for (int i = 0; i < 300 && !taken; i++) begin
      @(negedge clk);
      if (!busy && !flush) begin
        chk("int_in_ready", in_ready, 0);
        push_seq(7, 48'h0, pc, 1'b1);
        taken = 1;
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    handle_int = 1'b0; in_valid = 1'b0;
    if (!taken) chk("int_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && exp_q.size() == 0 && !out_valid;
    end
    @(posedge clk);
    #1;
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; handle_int = 1'b0; in_valid = 1'b0;
    in_seq_valid = 1'b0; in_seq_id = '0; in_uop = '0; in_imm = '0; in_pc = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_int_done", handle_int_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_uop", out_uop, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_pc", out_pc, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Pass-through: one-cycle latency.
    send(0, 0, 64'hA5, 48'h0, 32'h100);
    @(negedge clk);
    chk("pt_valid", out_valid, 1);
    chk("pt_uop", out_uop, 64'hA5);
    chk("pt_last", out_last, 1);
    @(posedge clk);
    #1;

    // Sequence 2, length 3: N+1 cycles from accept.
    send(1, 2, 64'h0, 48'h1234, 32'h200);
    @(negedge clk);
    chk("seq_busy", busy, 1);
    chk("seq_gap_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    chk("seq_mid_last", out_last, 0);
    @(negedge clk);
    chk("seq_end_busy", busy, 0);
    chk("seq_end_last", out_last, 1);
    @(posedge clk);
    #1;
    wait_idle();

    // Back-pressure: stall four cycles while step 1 is presented.
    send(1, 3, 64'h0, 48'hBEEF, 32'h300);
    repeat (2) @(negedge clk);
    rdy_mode = 2;
    @(negedge clk);
    chk("bp_step", out_uop[7:0], 1);
    repeat (3) @(negedge clk);
    rdy_mode = 1;
    @(posedge clk);
    #1;
    wait_idle();

    // Interrupt with a competing instruction, then flush+interrupt together.
    do_int(0);
    wait_idle();
    do_int(1);
    wait_idle();

    // Flush while step 2 of a five-step sequence is presented.
    send(1, 3, 64'h0, 48'h77, 32'h400);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_step", out_uop[7:0], 2);
    @(posedge clk);
    #1;
    flush = 1'b0;
    send(0, 0, 64'h1111, 48'h1, 32'h500);
    wait_idle();

    // Runaway sequence terminates on the step limit.
    send(1, 4, 64'h0, 48'h99, 32'h600);
    wait_idle();

    // Randomized traffic with random back-pressure.
    rdy_mode = 0;
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) do_int($urandom_range(0, 1));
      else if (r == 1) begin
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
      end else begin
        send($urandom_range(0, 1), $urandom_range(0, 7), {$urandom, $urandom},
             {$urandom, $urandom}, $urandom);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 1;
    wait_idle();

    // Reset in the middle of a sequence restarts in IDLE.
    send(1, 5, 64'h0, 48'h42, 32'h700);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_uop", out_uop, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send(0, 0, 64'h2222, 48'h2, 32'h800);
    wait_idle();
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uop_sequencer.md
UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 Parameter UOPW, default 64: micro-op payload width.
REQ-002 Parameter SEQS, default 8: number of ROM sequences; SEQW = clog2(SEQS).
REQ-003 Parameter MAXLEN, default 8: maximum micro-ops per sequence; STPW = clog2(MAXLEN).
REQ-004 Parameter IADDRW, default 32: PC width.
REQ-005 Parameter INT_SEQ, default SEQS-1: sequence id of the interrupt entry sequence.
REQ-006 Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  squash everything; return to IDLE.
- handle_int  in  1  level; interrupt pending.
- handle_int_done  out  1  one-cycle pulse when the last interrupt micro-op is accepted downstream.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  instruction accepted when in_valid and in_ready are both high.
- in_uop  in  UOPW  directly decoded micro-op.
- in_seq_valid  in  1  instruction requires a ROM sequence.
- in_seq_id  in  SEQW  ROM sequence selector.
- in_imm  in  48  immediate captured for the whole sequence.
- in_pc  in  IADDRW  instruction PC.
- out_valid  out  1  output micro-op valid.
- out_ready  in  1  downstream accept.
- out_uop  out  UOPW  micro-op.
- out_imm  out  48  immediate.
- out_pc  out  IADDRW  PC.
- out_last  out  1  final micro-op of the instruction.
- busy  out  1  high in SEQ or INT state.

Function
REQ-007 FSM states: IDLE, SEQ and INT.
REQ-008 Output register loads when out_valid is low or out_ready is high (load condition, LD).
REQ-009 In IDLE with handle_int low, in_ready equals LD.
- On accept with in_seq_valid low: register in_uop, in_imm and in_pc with out_last=1.
REQ-010 In IDLE, accept with in_seq_valid high:
- Capture in_seq_id, in_imm and in_pc.
- Set step=0 and enter SEQ.
- Nothing is emitted that cycle.
REQ-011 In SEQ and INT, in_ready is 0.
REQ-012 In SEQ and INT, each LD cycle emits rom(seq, step).uop together with the captured imm and pc.
- out_last is set when rom.last=1 or step=MAXLEN-1 (forced termination).
REQ-013 After an emitted last micro-op the FSM returns to IDLE; otherwise step increments by one.
- The step counter never wraps.
REQ-014 In IDLE, handle_int high takes priority over in_valid:
- in_ready is 0.
- Enter INT with seq=INT_SEQ, step=0, and pc taken from in_pc.
REQ-015 handle_int_done pulses for exactly the cycle in which the INT last micro-op is accepted by downstream (out_valid, out_ready and out_last all high).
REQ-016 flush (synchronous) has the following effect:
- Next state is IDLE, out_valid=0 and step=0.
- A pending handle_int_done is suppressed.
- in_ready is 0 during the flush cycle.
REQ-017 Simultaneous flush and handle_int: flush wins; the interrupt is taken the cycle after flush deasserts if handle_int is still high.
REQ-018 A stalled output (out_valid=1, out_ready=0) holds all out_* stable and does not advance step.
REQ-019 Throughput is one micro-op per cycle with a 1-cycle latency from accept to out_valid (pass-through case).
- A ROM sequence of length N occupies N+1 cycles from accept.

Reset
REQ-020 While reset is low:
- State=IDLE and step=0.
- out_valid, out_last, handle_int_done and busy are 0.
- out_uop, out_imm and out_pc are 0.
REQ-021 Reset deassertion mid-sequence restarts in IDLE; no partial sequence resumes.

Structure
REQ-022 The shared decode package holds the state encoding and a ROM entry layout of {last, uop[UOPW-1:0]}.
REQ-023 One combinational sub-module, uop_rom, maps (seq, step) to the ROM entry.
- Unprogrammed entries read as uop=0, last=1.
REQ-024 All flops in uop_sequencer use the codebase register primitives.

Verification
REQ-025 Pass-through: in_seq_valid=0, in_uop=0xA5, in_pc=0x100, out_ready=1. Required response: next cycle out_valid=1, out_uop=0xA5, out_last=1.
REQ-026 Sequence: seq_id=2 of length 3, in_imm=0x1234. Required response:
- Three micro-ops on consecutive cycles, each with out_imm=0x1234.
- out_last only on the third.
- in_ready=0 throughout; IDLE afterwards.
REQ-027 Back-pressure: out_ready=0 for 4 cycles at step 1. Required response: out_uop stable for those cycles, step held, and after release the sequence completes with no micro-op lost or duplicated.
REQ-028 Interrupt: handle_int=1 while in_valid=1 in IDLE. Required response:
- Instruction not accepted and INT sequence emitted.
- handle_int_done pulses once, coincident with acceptance of the last micro-op.
REQ-029 Flush mid-sequence at step 2 of 5. Required response:
- out_valid=0 next cycle and state IDLE.
- No handle_int_done.
- Next instruction accepted normally.
REQ-030 Runaway: a sequence with no last bit and MAXLEN=8. Required response: exactly 8 micro-ops emitted, with out_last forced on step 7.
